keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/keypad_scanner.sv | 247 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    // Matrix geometry.
    localparam int COLS = 4;
    localparam int ROWS = 4;

    // Width of a scan result: bit 4 flags "no key", bits 3:0 carry col*4 + row.
    localparam int RESULT_W = 5;

    // Scan result meaning "no key seen during the whole scan".
    localparam logic [RESULT_W-1:0] NONE = 5'h10;

    // Debounce / acceptance state machine.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // True when a scan result carries no key.
    function automatic logic is_none(input logic [RESULT_W-1:0] result);
        return result[RESULT_W-1];
    endfunction

    // Build a scan result from a column index and a row index.
    function automatic logic [RESULT_W-1:0] make_code(input logic [1:0] col,
                                                      input logic [1:0] row);
        return {1'b0, col, row};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent, slowly changing levels.
// Resets to all ones because the keypad rows idle high through pull-ups.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples
// the synchronized rows at the end of each column dwell, reduces each full
// scan to the lowest pressed code, and debounces press and release over
// DB_SCANS consecutive identical scans.
//
// Handshake note: there is no backpressure. key_valid and key_release are
// single-cycle strobes that appear in the cycle after the deciding scan end;
// key_held is a level between them and key_code is stable whenever
// key_valid is high and keeps its value after release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = 50000,
    parameter int DB_SCANS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release
);

    // Dwell counter sized to hold SCAN_TICKS-1.
    localparam int DW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
    localparam logic [7:0]    DB_LIMIT   = 8'(DB_SCANS);

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [ROWS-1:0] row_sync;

    sync_2ff #(
        .WIDTH (ROWS)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_sync)
    );

    // ------------------------------------------------------------------
    // Column scan timer
    // ------------------------------------------------------------------
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic          dwell_end;
    logic          scan_end;

    assign dwell_end = (dwell == DWELL_LAST);
    assign scan_end  = dwell_end && (col == 2'd3);

    // Dwell counter wraps at SCAN_TICKS-1 and steps the column on the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
            col   <= 2'd0;
        end else if (dwell_end) begin
            dwell <= '0;
            col   <= col + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Drive exactly one column low: the current column index.
    always_comb begin
        col_out = ~(4'b0001 << col);
    end

    // ------------------------------------------------------------------
    // Per-scan reduction to the lowest pressed code
    // ------------------------------------------------------------------
    logic [RESULT_W-1:0] col_hit;     // lowest pressed key in the current column
    logic [RESULT_W-1:0] scan_best;   // lowest key seen so far in this scan
    logic [RESULT_W-1:0] scan_result; // best including the current column

    // Lowest pressed row wins inside a column (scan high to low, last write wins).
    always_comb begin
        col_hit = NONE;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_sync[r]) begin
                col_hit = make_code(col, 2'(r));
            end
        end
    end

    // Columns are visited in ascending order, so the first hit of a scan is
    // always the lowest code; later columns only fill in when nothing was seen.
    always_comb begin
        scan_result = is_none(scan_best) ? col_hit : scan_best;
    end

    // Accumulate across columns; start fresh after the last column.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_best <= NONE;
        end else if (dwell_end) begin
            scan_best <= (col == 2'd3) ? NONE : scan_result;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [7:0] cnt_inc;
    logic [3:0] cand;
    logic [3:0] cand_n;
    logic [3:0] code_n;
    logic       held_n;
    logic       valid_n;
    logic       release_n;

    // Scan counter saturates rather than wrapping.
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // State register plus registered outputs, updated from the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            cand        <= 4'd0;
            key_code    <= 4'd0;
            key_held    <= 1'b0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cand        <= cand_n;
            key_code    <= code_n;
            key_held    <= held_n;
            key_valid   <= valid_n;
            key_release <= release_n;
        end
    end

    // Next-state and output decisions, taken only at the end of a full scan.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        code_n    = key_code;
        held_n    = key_held;
        valid_n   = 1'b0;
        release_n = 1'b0;

        if (scan_end) begin
            case (state)
                ST_IDLE: begin
                    if (!is_none(scan_result)) begin
                        cand_n = scan_result[3:0];
                        cnt_n  = 8'd1;
                        if (DB_LIMIT <= 8'd1) begin
                            state_n = ST_PRESSED;
                            code_n  = scan_result[3:0];
                            held_n  = 1'b1;
                            valid_n = 1'b1;
                        end else begin
                            state_n = ST_DEBOUNCE;
                        end
                    end else begin
                        cnt_n = 8'd0;
                    end
                end

                ST_DEBOUNCE: begin
                    if (scan_result == {1'b0, cand}) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DB_LIMIT) begin
                            state_n = ST_PRESSED;
                            code_n  = cand;
                            held_n  = 1'b1;
                            valid_n = 1'b1;
                        end
                    end else begin
                        // A different key or an empty scan abandons the candidate.
                        state_n = ST_IDLE;
                        cnt_n   = 8'd0;
                    end
                end

                ST_PRESSED: begin
                    // Any key keeps the press alive; only an empty scan starts release.
                    if (is_none(scan_result)) begin
                        cnt_n = 8'd1;
                        if (DB_LIMIT <= 8'd1) begin
                            state_n   = ST_IDLE;
                            cnt_n     = 8'd0;
                            held_n    = 1'b0;
                            release_n = 1'b1;
                        end else begin
                            state_n = ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (is_none(scan_result)) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DB_LIMIT) begin
                            state_n   = ST_IDLE;
                            cnt_n     = 8'd0;
                            held_n    = 1'b0;
                            release_n = 1'b1;
                        end
                    end else begin
                        // Re-contact: the original press is still in force.
                        state_n = ST_PRESSED;
                        cnt_n   = 8'd0;
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------

    // Press and release strobes are mutually exclusive.
    a_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(key_valid && key_release));

    // Each strobe lasts exactly one cycle.
    a_valid_single: assert property (@(posedge clk) disable iff (rst)
        key_valid |=> !key_valid);
    a_release_single: assert property (@(posedge clk) disable iff (rst)
        key_release |=> !key_release);

    // Exactly one column is driven low at any time.
    a_col_onehot: assert property (@(posedge clk)
        $onehot(~col_out));

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_TICKS=4, DB_SCANS=3.
// A keypad model turns a 16-bit "keys pressed" vector into row levels for
// whichever column is driven. The reference model works a whole scan at a
// time: the scan result is the lowest pressed key index, and press/release
// acceptance is tracked as run lengths of identical scan results.
module tb_keypad_scanner;

    localparam int SCAN_TICKS = 4;
    localparam int DB_SCANS   = 3;
    localparam int SCAN_CYC   = 4 * SCAN_TICKS;

    // ------------------------------------------------------------------
    // Clock and reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_release;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_TICKS (SCAN_TICKS),
        .DB_SCANS   (DB_SCANS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release)
    );

    // ------------------------------------------------------------------
    // Keypad matrix: a pressed key shorts its row to its column
    // ------------------------------------------------------------------
    logic [15:0] keys = 16'h0000;

    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c * 4 + r]) row_in[r] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard counters and checker
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (scan granularity)
    // ------------------------------------------------------------------
    logic       m_held;
    logic [3:0] m_code;
    logic       m_pend_valid;
    logic       m_pend_release;
    int         m_streak;   // identical key scans while not held
    int         m_cand;
    int         m_gap;      // consecutive empty scans while held
    int         n_valid_seen;
    int         n_release_seen;

    function automatic int lowest_key(input logic [15:0] k);
        for (int i = 0; i < 16; i++) begin
            if (k[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_held         = 1'b0;
        m_code         = 4'd0;
        m_pend_valid   = 1'b0;
        m_pend_release = 1'b0;
        m_streak       = 0;
        m_cand         = 0;
        m_gap          = 0;
    endtask

    task automatic model_scan_end(input logic [15:0] k);
        int res;
        res            = lowest_key(k);
        m_pend_valid   = 1'b0;
        m_pend_release = 1'b0;
        if (!m_held) begin
            if (res < 0) begin
                m_streak = 0;
            end else if (m_streak == 0) begin
                m_cand   = res;
                m_streak = 1;
            end else if (res == m_cand) begin
                m_streak++;
            end else begin
                m_streak = 0;
            end
            if (m_streak == DB_SCANS) begin
                m_held       = 1'b1;
                m_code       = 4'(m_cand);
                m_pend_valid = 1'b1;
                m_streak     = 0;
                m_gap        = 0;
            end
        end else begin
            if (res < 0) begin
                m_gap++;
                if (m_gap == DB_SCANS) begin
                    m_held         = 1'b0;
                    m_pend_release = 1'b1;
                    m_gap          = 0;
                end
            end else begin
                m_gap = 0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------

    // One full scan with a fixed key set; entered one step after the edge
    // that starts column 0, leaves one step after the scan-end edge.
    task automatic run_scan(input logic [15:0] k);
        keys = k;
        for (int i = 0; i < SCAN_CYC; i++) begin
            @(negedge clk);
            check("col_out", 16'(col_out), 16'(~(4'b0001 << (i / SCAN_TICKS)) & 4'hF));
            check("key_valid", 16'(key_valid), 16'((i == 0) && m_pend_valid));
            check("key_release", 16'(key_release), 16'((i == 0) && m_pend_release));
            check("key_held", 16'(key_held), 16'(m_held));
            check("key_code", 16'(key_code), 16'(m_code));
            if (key_valid) n_valid_seen++;
            if (key_release) n_release_seen++;
            @(posedge clk);
            #1;
        end
        model_scan_end(k);
    endtask

    task automatic run_scans(input logic [15:0] k, input int n);
        for (int s = 0; s < n; s++) run_scan(k);
    endtask

    // Synchronous reset for three edges, checking outputs are cleared throughout.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_col_out", 16'(col_out), 16'h000E);
            check("rst_key_held", 16'(key_held), 16'h0);
            check("rst_key_valid", 16'(key_valid), 16'h0);
            check("rst_key_release", 16'(key_release), 16'h0);
            check("rst_key_code", 16'(key_code), 16'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] prev;
        logic [15:0] k;
        int          sel;
        int          v0;

        model_reset();
        n_valid_seen   = 0;
        n_release_seen = 0;

        // Reset state and idle column walk.
        do_reset();
        run_scans(16'h0000, 2);

        // Key 9 (column 2, row 1) held for five scans: accepted once.
        v0 = n_valid_seen;
        run_scans(16'h0200, 5);
        check("press9_valid_count", 16'(n_valid_seen - v0), 16'd1);
        check("press9_code", 16'(key_code), 16'h9);

        // Release with a one-scan re-contact after one clean scan.
        v0 = n_release_seen;
        run_scan(16'h0000);
        run_scan(16'h0200);
        run_scans(16'h0000, 2);
        check("bounce_release_none", 16'(n_release_seen - v0), 16'd0);
        run_scans(16'h0000, 2);
        check("release_count", 16'(n_release_seen - v0), 16'd1);
        check("release_code_kept", 16'(key_code), 16'h9);

        // Press bounce: 2 present, 1 absent, 3 present -> one acceptance.
        v0 = n_valid_seen;
        run_scans(16'h0200, 2);
        run_scan(16'h0000);
        run_scans(16'h0200, 2);
        check("bounce_no_early_valid", 16'(n_valid_seen - v0), 16'd0);
        run_scans(16'h0200, 2);
        check("bounce_valid_count", 16'(n_valid_seen - v0), 16'd1);
        run_scans(16'h0000, 4);

        // Keys 5 and 2 together resolve to 2; adding key 0 gives no new press.
        run_scans(16'h0024, 4);
        check("multi_code", 16'(key_code), 16'h2);
        v0 = n_valid_seen;
        run_scans(16'h0025, 3);
        check("no_new_valid", 16'(n_valid_seen - v0), 16'd0);
        check("held_code_kept", 16'(key_code), 16'h2);

        // Reset while held: no release strobe, then re-acceptance.
        v0 = n_release_seen;
        do_reset();
        check("reset_no_release", 16'(n_release_seen - v0), 16'd0);
        run_scans(16'h0025, 4);
        check("reaccept_held", 16'(key_held), 16'h1);
        run_scans(16'h0000, 4);

        // Randomized key activity with runs, gaps and multi-key presses.
        prev = 16'h0000;
        for (int n = 0; n < 90; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                k = prev;
            end else if (sel <= 5) begin
                k = 16'h0000;
            end else if (sel <= 7) begin
                k = 16'h0001 << $urandom_range(0, 15);
            end else begin
                k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            end
            run_scan(k);
            prev = k;
        end
        run_scans(16'h0000, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
